// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master drives operands and OutputReady; slave is the adder's view.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             InputValid;
    logic             InputReady;
    logic [WIDTH-1:0] InputA;
    logic [WIDTH-1:0] InputB;
    logic             InputCarry;
    logic             SubMode;
    logic             OutputValid;
    logic             OutputReady;
    logic [WIDTH-1:0] SumOut;
    logic             CarryOut;
    logic             Overflow;

    modport master (
        output InputValid, InputA, InputB, InputCarry, SubMode, OutputReady,
        input  InputReady, OutputValid, SumOut, CarryOut, Overflow
    );

    modport slave (
        input  InputValid, InputA, InputB, InputCarry, SubMode, OutputReady,
        output InputReady, OutputValid, SumOut, CarryOut, Overflow
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one SEG-bit segment per stage,
// least significant first, with a registered carry between stages and a
// global stall driven by the output handshake.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic              Clock,
    input logic              ResetN,
    pipelined_adder_if.slave bus
);
    localparam int SEG = WIDTH / STAGES;

    // The whole pipeline moves only when the output slot is free or draining.
    logic advance;

    assign advance        = !stage[STAGES-1].regValid || bus.OutputReady;
    assign bus.InputReady = advance && ResetN;

    // Stage k consumes the low SEG bits of the operands it receives and
    // forwards only the still-unprocessed upper bits; finished sum bits grow
    // by SEG per stage, so every stored bit is used downstream.
    for (genvar k = 0; k < STAGES; k++) begin : stage
        localparam int FW = WIDTH - k * SEG;  // operand bits still pending
        localparam int DW = (k + 1) * SEG;    // sum bits finished after stage

        logic [FW-1:0] feedA;
        logic [FW-1:0] feedB;
        logic          feedCarry;
        logic          feedValid;
        logic [SEG:0]  segResult;
        logic [DW-1:0] doneSum;

        logic          regValid;
        logic          regCarry;
        logic [DW-1:0] regSum;

        if (k == 0) begin : feed
            // Subtraction is A + ~B + 1; InputCarry is ignored in SubMode.
            assign feedA     = bus.InputA;
            assign feedB     = bus.SubMode ? ~bus.InputB : bus.InputB;
            assign feedCarry = bus.SubMode | bus.InputCarry;
            assign feedValid = bus.InputValid;
            assign doneSum   = segResult[SEG-1:0];
        end else begin : feed
            assign feedA     = stage[k-1].fwd.regA;
            assign feedB     = stage[k-1].fwd.regB;
            assign feedCarry = stage[k-1].regCarry;
            assign feedValid = stage[k-1].regValid;
            assign doneSum   = {segResult[SEG-1:0], stage[k-1].regSum};
        end

        assign segResult = {1'b0, feedA[SEG-1:0]} + {1'b0, feedB[SEG-1:0]}
                         + {{SEG{1'b0}}, feedCarry};

        // Stage result register: valid bit, carry into the next segment and
        // the finished low sum bits.
        always_ff @(posedge Clock or negedge ResetN) begin
            if (!ResetN) begin
                regValid <= 1'b0;
                regCarry <= 1'b0;
                regSum   <= '0;
            end else if (advance) begin
                regValid <= feedValid;
                regCarry <= segResult[SEG];
                regSum   <= doneSum;
            end
        end

        if (k < STAGES - 1) begin : fwd
            logic [FW-SEG-1:0] regA;
            logic [FW-SEG-1:0] regB;

            // Delay registers carrying the upper operand segments forward.
            always_ff @(posedge Clock or negedge ResetN) begin
                if (!ResetN) begin
                    regA <= '0;
                    regB <= '0;
                end else if (advance) begin
                    regA <= feedA[FW-1:SEG];
                    regB <= feedB[FW-1:SEG];
                end
            end
        end else begin : fin
            logic regOverflow;

            // Carry into the MSB is a^b^sum at that bit; overflow is it XOR carry-out.
            always_ff @(posedge Clock or negedge ResetN) begin
                if (!ResetN) begin
                    regOverflow <= 1'b0;
                end else if (advance) begin
                    regOverflow <= feedA[FW-1] ^ feedB[FW-1]
                                 ^ segResult[SEG-1] ^ segResult[SEG];
                end
            end
        end
    end

    assign bus.OutputValid = stage[STAGES-1].regValid;
    assign bus.SumOut      = stage[STAGES-1].regSum;
    assign bus.CarryOut    = stage[STAGES-1].regCarry;
    assign bus.Overflow    = stage[STAGES-1].fin.regOverflow;
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vector table on the
// STAGES=4 instance, multi-cycle corner sequences, and a random sweep that
// drives STAGES=4, 1 and 16 instances in parallel against a scoreboard.
module tb_pipelined_adder;
    localparam int WIDTH = 16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        inValid = 1'b0;
    logic        inCarry = 1'b0;
    logic        subMode = 1'b0;
    logic        outReady = 1'b1;
    logic [15:0] inA = '0;
    logic [15:0] inB = '0;
    bit          checkLat = 1'b1;
    int          nChecks = 0;
    int          nFails = 0;
    vec_t        vecs[11];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference result {Overflow, CarryOut, SumOut} using the sign rule.
    function automatic logic [17:0] refModel(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin, input logic sub);
        logic [15:0] bb;
        logic [16:0] r;
        bb = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + (sub ? 17'd1 : {16'd0, cin});
        return {(a[15] == bb[15]) && (r[15] != a[15]), r[16], r[15:0]};
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int STG = (gi == 0) ? 4 : ((gi == 1) ? 1 : 16);

        pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

        assign bus.InputValid  = inValid;
        assign bus.InputA      = inA;
        assign bus.InputB      = inB;
        assign bus.InputCarry  = inCarry;
        assign bus.SubMode     = subMode;
        assign bus.OutputReady = outReady;

        pipelined_adder #(.WIDTH(WIDTH), .STAGES(STG)) dut (
            .Clock (clk),
            .ResetN(rstN),
            .bus   (bus.slave)
        );

        logic [17:0] expQ[$];
        int          tsQ[$];
        int          cyc = 0;
        int          pending = 0;
        logic [17:0] expVal;
        int          expTs;

        // Scoreboard: handshakes sampled mid-cycle complete at the next posedge.
        always @(negedge clk or negedge rstN) begin
            if (!rstN) begin
                expQ.delete();
                tsQ.delete();
                pending = 0;
            end else begin
                cyc++;
                if (bus.OutputValid && outReady) begin
                    if (expQ.size() == 0) begin
                        chk($sformatf("S%0d unexpected OutputValid", STG), 32'(bus.OutputValid), 32'd0);
                    end else begin
                        expVal = expQ.pop_front();
                        expTs  = tsQ.pop_front();
                        chk($sformatf("S%0d result", STG),
                            {14'd0, bus.Overflow, bus.CarryOut, bus.SumOut}, {14'd0, expVal});
                        if (checkLat)
                            chk($sformatf("S%0d latency", STG), 32'(cyc - expTs), 32'(STG));
                    end
                end
                if (inValid && bus.InputReady) begin
                    expQ.push_back(refModel(inA, inB, inCarry, subMode));
                    tsQ.push_back(cyc);
                end
                pending = expQ.size();
            end
        end
    end

    task automatic applyOne(input vec_t v, input string tag);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        inA = v.a; inB = v.b; inCarry = v.cin; subMode = v.sub; inValid = 1'b1;
        chk({tag, " ready"}, 32'(g[0].bus.InputReady), 32'd1);
        @(posedge clk); #1;
        inValid = 1'b0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge clk);
            if (g[0].bus.OutputValid) lat = n;
        end
        chk({tag, " latency"}, 32'(lat), 32'd4);
        chk({tag, " sum"}, 32'(g[0].bus.SumOut), 32'(v.sum));
        chk({tag, " carry"}, 32'(g[0].bus.CarryOut), 32'(v.cout));
        chk({tag, " overflow"}, 32'(g[0].bus.Overflow), 32'(v.ovf));
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (n < 200 && (g[0].pending + g[1].pending + g[2].pending) != 0) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, " drain S4"}, 32'(g[0].pending), 32'd0);
        chk({tag, " drain S1"}, 32'(g[1].pending), 32'd0);
        chk({tag, " drain S16"}, 32'(g[2].pending), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        logic [17:0] e;
        int          idx;

        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[2]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[3]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5]  = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{16'h5555, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};
        vecs[9]  = '{16'h0003, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[10] = '{16'h0001, 16'h0003, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};

        // Reset state
        #2 rstN = 1'b0;
        #10;
        chk("reset OutputValid", 32'(g[0].bus.OutputValid), 32'd0);
        chk("reset SumOut", 32'(g[0].bus.SumOut), 32'd0);
        chk("reset CarryOut", 32'(g[0].bus.CarryOut), 32'd0);
        chk("reset Overflow", 32'(g[0].bus.Overflow), 32'd0);
        chk("reset InputReady", 32'(g[0].bus.InputReady), 32'd0);
        @(posedge clk); #3 rstN = 1'b1;

        // Directed vector table
        for (int i = 0; i < 11; i++) applyOne(vecs[i], $sformatf("vec%0d", i));
        waitDrain("table");

        // Full throughput: 8 back-to-back, alternating add/sub
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(posedge clk); #1;
                    inValid = 1'b1; inA = 16'(i) * 16'h1111; inB = 16'h0F0F;
                    inCarry = 1'b0; subMode = i[0];
                end
                @(posedge clk); #1 inValid = 1'b0;
            end
            begin
                idx = 0;
                @(posedge clk);
                @(posedge clk);
                for (int n = 1; n <= 12; n++) begin
                    @(negedge clk);
                    chk($sformatf("burst valid n=%0d", n), 32'(g[0].bus.OutputValid),
                        32'(n >= 4 && n <= 11));
                    if (g[0].bus.OutputValid && idx < 8) begin
                        e = refModel(16'(idx) * 16'h1111, 16'h0F0F, 1'b0, idx[0]);
                        chk($sformatf("burst result %0d", idx),
                            {14'd0, g[0].bus.Overflow, g[0].bus.CarryOut, g[0].bus.SumOut}, {14'd0, e});
                        idx++;
                    end
                end
            end
        join
        waitDrain("burst");

        // Backpressure with a full pipeline
        checkLat = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            inValid = 1'b1; inA = 16'h0101 * 16'(i + 1); inB = 16'h1000;
            inCarry = 1'b0; subMode = 1'b0;
        end
        outReady = 1'b0;
        @(negedge clk);
        held = g[0].bus.SumOut;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("stall InputReady", 32'(g[0].bus.InputReady), 32'd0);
            chk("stall OutputValid", 32'(g[0].bus.OutputValid), 32'd1);
            chk("stall SumOut", 32'(g[0].bus.SumOut), 32'(held));
        end
        @(posedge clk); #1 outReady = 1'b1;
        @(posedge clk); #1 inValid = 1'b0;
        waitDrain("backpressure");
        checkLat = 1'b1;

        // Asynchronous reset with transactions in flight
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            inValid = 1'b1; inA = 16'h1111 * 16'(i + 1); inB = 16'h0202;
            inCarry = 1'b0; subMode = 1'b0;
        end
        @(posedge clk); #1 inValid = 1'b0;
        chk("pre-reset OutputValid", 32'(g[0].bus.OutputValid), 32'd1);
        #2 rstN = 1'b0;
        #1;
        chk("midreset OutputValid", 32'(g[0].bus.OutputValid), 32'd0);
        chk("midreset SumOut", 32'(g[0].bus.SumOut), 32'd0);
        chk("midreset CarryOut", 32'(g[0].bus.CarryOut), 32'd0);
        chk("midreset Overflow", 32'(g[0].bus.Overflow), 32'd0);
        chk("midreset InputReady", 32'(g[0].bus.InputReady), 32'd0);
        @(posedge clk);
        @(posedge clk); #3 rstN = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("post-reset stale valid",
                32'(g[0].bus.OutputValid | g[1].bus.OutputValid | g[2].bus.OutputValid), 32'd0);
        end
        applyOne(vecs[3], "post-reset");
        waitDrain("reset");

        // Random sweep across STAGES=4, 1, 16 at full rate
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            inValid = 1'b1;
            inA = 16'($urandom);
            inB = 16'($urandom);
            inCarry = 1'($urandom_range(0, 1));
            subMode = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1 inValid = 1'b0;
        waitDrain("sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
